pllphase_div_param: RTL and testbench

//  Parametrised PLL post-divider / phase generator. Divides CLK by a runtime-programmable

---
 rtl/pllphase_div_param.sv | 123 ++++++++++++
 tb/tb_pllphase_div_param.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pllphase_div_param.sv
// Programmable CLK/N divider with whole-cycle phase offset, plus fixed CLK/2 and quadrature CLK/4.
// New ratio/phase values are staged in shadow registers and take effect only at a counter wrap.
module pllphase_div_param #(
    parameter int DIV_W   = 5,
    parameter int MAX_DIV = 16,
    parameter int DEF_DIV = 7
) (
    input  logic             CLK,
    input  logic             sr,
    input  logic [DIV_W-1:0] div_sel,
    input  logic [DIV_W-1:0] phase_sel,
    input  logic             upd,
    output logic             busy,
    output logic             upd_ack,
    output logic             f_out,
    output logic             sync,
    output logic             f_dvd2,
    output logic             f_dvd4_p0,
    output logic             f_dvd4_p90
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

    state_t           state;
    state_t           state_nx;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] n_act;
    logic [DIV_W-1:0] p_act;
    logic [DIV_W-1:0] n_sh;
    logic [DIV_W-1:0] p_sh;
    logic [DIV_W-1:0] n_clamp;
    logic [DIV_W-1:0] p_clamp;
    logic             wrap;
    logic             capture;
    logic             apply;
    logic [DIV_W:0]   pos_raw;
    logic [DIV_W:0]   pos;
    logic [DIV_W:0]   half;

    assign wrap = (cnt == n_act - DIV_W'(1));

    always_comb begin
        n_clamp = div_sel;
        if (div_sel < DIV_W'(2)) begin
            n_clamp = DIV_W'(2);
        end else if (div_sel > DIV_W'(MAX_DIV)) begin
            n_clamp = DIV_W'(MAX_DIV);
        end
        p_clamp = phase_sel % n_clamp;
    end

    // Position within the shifted period; one extra bit so cnt < p_act never underflows.
    always_comb begin
        pos_raw = {1'b0, cnt} + {1'b0, n_act} - {1'b0, p_act};
        pos     = pos_raw;
        if (pos_raw >= {1'b0, n_act}) begin
            pos = pos_raw - {1'b0, n_act};
        end
        half = ({1'b0, n_act} + (DIV_W+1)'(1)) >> 1;
    end

    always_ff @(posedge CLK) begin
        if (sr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (upd)  state_nx = PEND;
            PEND:    if (wrap) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        capture = 1'b0;
        apply   = 1'b0;
        case (state)
            IDLE:    capture = upd;
            PEND:    apply   = wrap;
            default: ;
        endcase
    end

    assign busy = (state == PEND);

    always_ff @(posedge CLK) begin
        if (sr) begin
            cnt        <= '0;
            n_act      <= DIV_W'(DEF_DIV);
            p_act      <= '0;
            n_sh       <= '0;
            p_sh       <= '0;
            upd_ack    <= 1'b0;
            f_out      <= 1'b0;
            sync       <= 1'b0;
            f_dvd2     <= 1'b0;
            f_dvd4_p0  <= 1'b0;
            f_dvd4_p90 <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + DIV_W'(1);
            if (apply) begin
                n_act <= n_sh;
                p_act <= p_sh;
            end
            if (capture) begin
                n_sh <= n_clamp;
                p_sh <= p_clamp;
            end
            upd_ack    <= apply;
            f_out      <= (pos < half);
            sync       <= (cnt == '0);
            f_dvd2     <= ~f_dvd2;
            f_dvd4_p0  <= ~f_dvd4_p90;
            f_dvd4_p90 <= f_dvd4_p0;
        end
    end

endmodule

// File: tb/tb_pllphase_div_param.sv
// Bench for pllphase_div_param: constant-driven directed sequences, a vector table of
// update/clamp cases, and a long random run compared cycle by cycle against a reference model.
module tb_pllphase_div_param;

    localparam int DIV_W   = 5;
    localparam int MAX_DIV = 16;
    localparam int DEF_DIV = 7;

    logic             CLK = 1'b0;
    logic             sr;
    logic [DIV_W-1:0] div_sel;
    logic [DIV_W-1:0] phase_sel;
    logic             upd;
    logic             busy, upd_ack, f_out, sync, f_dvd2, f_dvd4_p0, f_dvd4_p90;

    pllphase_div_param #(.DIV_W(DIV_W), .MAX_DIV(MAX_DIV), .DEF_DIV(DEF_DIV)) dut (
        .CLK(CLK), .sr(sr), .div_sel(div_sel), .phase_sel(phase_sel), .upd(upd),
        .busy(busy), .upd_ack(upd_ack), .f_out(f_out), .sync(sync), .f_dvd2(f_dvd2),
        .f_dvd4_p0(f_dvd4_p0), .f_dvd4_p90(f_dvd4_p90)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference model state: settings, position in period, edges since reset.
    int       m_n, m_p, m_cnt, m_shn, m_shp, m_t, m_seg;
    bit       m_pend;
    logic [6:0] m_out;
    int       out_seg, out_min;

    // Pulse-width tracking on the DUT's f_out.
    int run_len, run_seg, run_min;
    bit run_val, run_clean;
    bit last_f, prev_f;

    typedef struct {
        int div_v;
        int phase_v;
        int exp_n;
        int exp_p;
    } vec_t;

    function automatic int clamp_n(input int d);
        if (d < 2) return 2;
        if (d > MAX_DIV) return MAX_DIV;
        return d;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int  n0, p0, c0;
        bit  was, f, s, ack;
        if (sr) begin
            m_n = DEF_DIV; m_p = 0; m_cnt = 0; m_shn = 0; m_shp = 0;
            m_t = 0; m_pend = 0; m_seg++;
            m_out   = '0;
            out_seg = -1;
            out_min = 0;
        end else begin
            n0 = m_n; p0 = m_p; c0 = m_cnt; was = m_pend;
            f = (((c0 - p0 + n0) % n0) < ((n0 + 1) / 2));
            s = (c0 == 0);
            out_seg = m_seg;
            out_min = n0 / 2;
            m_t++;
            ack = 0;
            if (was && c0 == n0 - 1) begin
                m_n = m_shn; m_p = m_shp; m_pend = 0; ack = 1; m_seg++;
            end
            m_cnt = (c0 == n0 - 1) ? 0 : c0 + 1;
            if (!was && upd) begin
                m_shn  = clamp_n(int'(div_sel));
                m_shp  = int'(phase_sel) % m_shn;
                m_pend = 1;
            end
            m_out = {m_pend, ack, f, s, (m_t % 2 == 1),
                     (m_t % 4 == 1 || m_t % 4 == 2), (m_t % 4 == 2 || m_t % 4 == 3)};
        end
    endtask

    task automatic step();
        logic [6:0] act;
        @(posedge CLK);
        model_edge();
        #1;
        act = {busy, upd_ack, f_out, sync, f_dvd2, f_dvd4_p0, f_dvd4_p90};
        checks++;
        if (act !== m_out) begin
            errors++;
            $display("FAIL model_cmp: got %b expected %b at %0t", act, m_out, $time);
        end
        if (out_seg == run_seg && f_out == run_val) begin
            run_len++;
        end else begin
            if (out_seg == run_seg && run_clean) begin
                checks++;
                if (run_len < run_min) begin
                    errors++;
                    $display("FAIL pulse_width: got %0d expected >= %0d at %0t", run_len, run_min, $time);
                end
            end
            run_clean = (out_seg == run_seg);
            run_val   = f_out;
            run_seg   = out_seg;
            run_len   = 1;
            run_min   = out_min;
        end
        prev_f = last_f;
        last_f = f_out;
    endtask

    task automatic issue_upd(input int d, input int p);
        div_sel   = DIV_W'(d);
        phase_sel = DIV_W'(p);
        upd       = 1'b1;
        step();
        upd = 1'b0;
    endtask

    task automatic wait_ack(input string name, output int lat);
        bit seen;
        seen = 0;
        lat  = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step();
            lat++;
            if (upd_ack) seen = 1;
        end
        check({name, "_ack_seen"}, int'(seen), 1);
        check({name, "_busy_at_ack"}, int'(busy), 0);
    endtask

    // Skip to a sync, then measure one full period: length, rise offset, high count.
    task automatic measure(input string name, input int exp_n, input int exp_p);
        int per, rise, hi;
        bit got;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (sync) got = 1;
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            if (sync) got = 1;
        end
        check({name, "_sync_found"}, int'(got), 1);
        rise = (f_out && !prev_f) ? 0 : -1;
        hi   = f_out ? 1 : 0;
        per  = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (sync) break;
            if (f_out && !prev_f && rise < 0) rise = per;
            if (f_out) hi++;
            per++;
        end
        check({name, "_period"}, per, exp_n);
        check({name, "_rise_ofs"}, rise, exp_p);
        check({name, "_high_cnt"}, hi, (exp_n + 1) / 2);
    endtask

    initial begin
        vec_t       vecs [8];
        logic [1:0] dvd4_exp [4];
        int         lat, acks;

        vecs[0] = '{div_v: 4,  phase_v: 1,  exp_n: 4,  exp_p: 1};
        vecs[1] = '{div_v: 0,  phase_v: 0,  exp_n: 2,  exp_p: 0};
        vecs[2] = '{div_v: 31, phase_v: 0,  exp_n: 16, exp_p: 0};
        vecs[3] = '{div_v: 4,  phase_v: 9,  exp_n: 4,  exp_p: 1};
        vecs[4] = '{div_v: 1,  phase_v: 5,  exp_n: 2,  exp_p: 1};
        vecs[5] = '{div_v: 16, phase_v: 15, exp_n: 16, exp_p: 15};
        vecs[6] = '{div_v: 7,  phase_v: 3,  exp_n: 7,  exp_p: 3};
        vecs[7] = '{div_v: 17, phase_v: 20, exp_n: 16, exp_p: 4};
        dvd4_exp[0] = 2'b10; dvd4_exp[1] = 2'b11; dvd4_exp[2] = 2'b01; dvd4_exp[3] = 2'b00;

        m_seg = 0; run_seg = -2; run_len = 0; run_min = 0; run_val = 0; run_clean = 0;
        last_f = 0; prev_f = 0;
        sr = 1'b1; upd = 1'b0; div_sel = '0; phase_sel = '0;
        for (int i = 0; i < 3; i++) step();
        check("reset_outs", int'({busy, upd_ack, f_out, sync, f_dvd2, f_dvd4_p0, f_dvd4_p90}), 0);
        sr = 1'b0;

        // Default ratio 7, no phase: 4 high / 3 low, sync at the rise.
        for (int i = 0; i < 28; i++) begin
            step();
            check("def_f_out", int'(f_out), int'((i % 7) < 4));
            check("def_sync", int'(sync), int'((i % 7) == 0));
            check("dvd2", int'(f_dvd2), int'((i % 2) == 0));
            check("dvd4", int'({f_dvd4_p0, f_dvd4_p90}), int'(dvd4_exp[i % 4]));
        end

        foreach (vecs[k]) begin
            repeat ($urandom_range(1, 5)) step();
            issue_upd(vecs[k].div_v, vecs[k].phase_v);
            check("busy_after_upd", int'(busy), 1);
            wait_ack("vec", lat);
            step();
            check("ack_one_cycle", int'(upd_ack), 0);
            measure("vec", vecs[k].exp_n, vecs[k].exp_p);
        end

        // Second request while busy must be ignored.
        issue_upd(4, 1);
        div_sel = DIV_W'(9); phase_sel = DIV_W'(2); upd = 1'b1;
        step(); step();
        upd = 1'b0;
        check("busy_hold", int'(busy), 1);
        wait_ack("ignore", lat);
        measure("ignore", 4, 1);

        // Reset while busy discards the request and restores the default ratio.
        issue_upd(5, 0);
        step();
        sr = 1'b1; step(); sr = 1'b0;
        acks = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (upd_ack) acks++;
        end
        check("sr_no_ack", acks, 0);
        check("sr_busy", int'(busy), 0);
        measure("sr_default", 7, 0);

        // Request accepted on the wrap edge applies one full period later.
        for (int i = 0; i < 10 && m_cnt != 6; i++) step();
        check("wrap_align", m_cnt, 6);
        issue_upd(3, 0);
        wait_ack("same_edge", lat);
        check("same_edge_latency", lat, 7);
        measure("same_edge", 3, 0);

        for (int i = 0; i < 10000; i++) begin
            sr        = ($urandom_range(0, 499) == 0);
            upd       = ($urandom_range(0, 7) == 0);
            div_sel   = DIV_W'($urandom_range(0, 31));
            phase_sel = DIV_W'($urandom_range(0, 31));
            step();
        end
        sr = 1'b0; upd = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
